// File: rtl/shifter_pkg.sv
// Shared operation encoding and pipeline sizing helpers for pipelined_shifter.
// Build option SHIFTER_ROTATE_EN: when defined, op 11 rotates right; otherwise op 11 acts as SRL.
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_SRL = 2'b00,
        SH_SRA = 2'b01,
        SH_SLL = 2'b10,
        SH_ROR = 2'b11
    } shift_op_e;

    function automatic int calc_levels(input int width);
        return $clog2(width);
    endfunction

    // Levels per register group; the final group may end up short or empty.
    function automatic int calc_levels_per_stage(input int width, input int stages);
        return (calc_levels(width) + stages - 1) / stages;
    endfunction

`ifdef SHIFTER_ROTATE_EN
    localparam bit ROT_SUPPORTED = 1'b1;
`else
    localparam bit ROT_SUPPORTED = 1'b0;
`endif

endpackage

// File: rtl/shift_level.sv
// One logarithmic level of the barrel shifter: optionally moves data right by DIST,
// refilling the vacated MSBs with the fill bit or, when rotating, with the bits shifted out.
module shift_level #(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic             fill,
    input  logic             rotate,
    output logic [WIDTH-1:0] result
);

    logic [DIST-1:0] upper;

    assign upper  = rotate ? data[DIST-1:0] : {DIST{fill}};
    assign result = en ? {upper, data[WIDTH-1:DIST]} : data;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SRL/SRA/SLL/ROR) with tag passthrough and valid/ready backpressure.
// Build option SHIFTER_ROTATE_EN (via shifter_pkg::ROT_SUPPORTED) enables the rotate wrap path.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [1:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_zero
);

    localparam int LEVELS = calc_levels(WIDTH);
    localparam int LPS    = calc_levels_per_stage(WIDTH, STAGES);

    logic adv;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
        return r;
    endfunction

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Each amount bit is delayed only until the stage that consumes it.
    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int SK = k / LPS;
        logic en;
        if (SK == 0) begin : g_direct
            assign en = in_amt[k];
        end else begin : g_delay
            logic [SK-1:0] dly;
            always_ff @(posedge clk) begin
                if (adv) begin
                    dly[0] <= in_amt[k];
                    for (int i = 1; i < SK; i++) dly[i] <= dly[i-1];
                end
            end
            assign en = dly[SK-1];
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [WIDTH-1:0]        d_in;
        shift_op_e               op_in;
        logic [TAG_W-1:0]        tag_in;
        logic                    vld_in;
        logic                    vld_p;
        logic                    rot;
        logic [LPS:0][WIDTH-1:0] chain;

        // Stage input: operands (SLL pre-reversed) or the previous stage register
        if (s == 0) begin : g_src
            assign op_in  = shift_op_e'(in_op);
            assign d_in   = (op_in == SH_SLL) ? bit_rev(in_data) : in_data;
            assign tag_in = in_tag;
            assign vld_in = in_valid;
        end else begin : g_src
            assign op_in  = g_stage[s-1].g_reg.op_p;
            assign d_in   = g_stage[s-1].g_reg.data_p;
            assign tag_in = g_stage[s-1].g_reg.tag_p;
            assign vld_in = g_stage[s-1].vld_p;
        end

        assign rot      = ROT_SUPPORTED && (op_in == SH_ROR);
        assign chain[0] = d_in;

        for (genvar j = 0; j < LPS; j++) begin : g_lv
            localparam int K = s * LPS + j;
            if (K < LEVELS) begin : g_on
                shift_level #(
                    .WIDTH (WIDTH),
                    .DIST  (1 << K)
                ) u_level (
                    .data   (chain[j]),
                    .en     (g_lvl[K].en),
                    .fill   ((op_in == SH_SRA) && chain[j][WIDTH-1]),
                    .rotate (rot),
                    .result (chain[j+1])
                );
            end else begin : g_pass
                assign chain[j+1] = chain[j];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)     vld_p <= 1'b0;
            else if (flush) vld_p <= 1'b0;
            else if (adv)   vld_p <= vld_in;
        end

        // Stage register boundary
        if (s < STAGES - 1) begin : g_reg
            logic [WIDTH-1:0] data_p;
            shift_op_e        op_p;
            logic [TAG_W-1:0] tag_p;
            always_ff @(posedge clk) begin
                if (adv) begin
                    data_p <= chain[LPS];
                    op_p   <= op_in;
                    tag_p  <= tag_in;
                end
            end
        end else begin : g_out
            logic [WIDTH-1:0] res;
            logic [WIDTH-1:0] data_p;
            logic [TAG_W-1:0] tag_p;
            logic             zero_p;
            assign res = (op_in == SH_SLL) ? bit_rev(chain[LPS]) : chain[LPS];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_p <= '0;
                    tag_p  <= '0;
                    zero_p <= 1'b1;
                end else if (adv) begin
                    data_p <= res;
                    tag_p  <= tag_in;
                    zero_p <= (res == '0);
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_p;
    assign out_data  = g_stage[STAGES-1].g_out.data_p;
    assign out_tag   = g_stage[STAGES-1].g_out.tag_p;
    assign out_zero  = g_stage[STAGES-1].g_out.zero_p;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Randomised self-checking bench for pipelined_shifter: a 32-bit two-stage instance plus
// 8-bit one- and three-stage instances, all checked against an arithmetic reference model.
module tb_pipelined_shifter;

`ifdef SHIFTER_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_amt, in_tag, out_tag;
    logic [1:0]  in_op;

    logic        s_valid, s_flush, s_ready;
    logic [7:0]  s_data, a_data, b_data;
    logic [2:0]  s_amt;
    logic [1:0]  s_op;
    logic [4:0]  s_tag, a_tag, b_tag;
    logic        a_ready, a_valid, a_zero, b_ready, b_valid, b_zero;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];
    exp_t qa[$];
    exp_t qb[$];

    pipelined_shifter #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_zero(out_zero));

    pipelined_shifter #(.WIDTH(8), .STAGES(1), .TAG_W(5)) dut8_s1 (
        .clk(clk), .rst_n(rst_n), .flush(s_flush), .in_valid(s_valid), .in_ready(a_ready),
        .in_data(s_data), .in_amt(s_amt), .in_op(s_op), .in_tag(s_tag),
        .out_valid(a_valid), .out_ready(s_ready), .out_data(a_data),
        .out_tag(a_tag), .out_zero(a_zero));

    pipelined_shifter #(.WIDTH(8), .STAGES(3), .TAG_W(5)) dut8_s3 (
        .clk(clk), .rst_n(rst_n), .flush(s_flush), .in_valid(s_valid), .in_ready(b_ready),
        .in_data(s_data), .in_amt(s_amt), .in_op(s_op), .in_tag(s_tag),
        .out_valid(b_valid), .out_ready(s_ready), .out_data(b_data),
        .out_tag(b_tag), .out_zero(b_zero));

    // Reference: plain arithmetic on a w-bit value held in 32 bits
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int amt,
                                              input logic [1:0] op, input int w);
        logic [31:0] mask, v;
        logic [1:0]  eff;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        v    = d & mask;
        eff  = (op == 2'b11 && !ROT) ? 2'b00 : op;
        case (eff)
            2'b00:   return v >> amt;
            2'b01:   return (v >> amt) | (v[w-1] ? (mask & ~(mask >> amt)) : 32'd0);
            2'b10:   return (v << amt) & mask;
            default: return (amt == 0) ? v : (((v >> amt) | (v << (w - amt))) & mask);
        endcase
    endfunction

    task automatic drive_op(input logic [31:0] d, input int amt, input logic [1:0] op,
                            input logic [4:0] tag);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = 5'(amt);
        in_op    = op;
        in_tag   = tag;
    endtask

    task automatic drive_random(input logic [4:0] tag);
        int amt;
        amt = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 31));
        drive_op($urandom, amt, 2'($urandom_range(0, 3)), tag);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_amt = '0; in_op = '0; in_tag = '0;
        s_valid = 1'b0; s_flush = 1'b0; s_ready = 1'b1;
        s_data = '0; s_amt = '0; s_op = '0; s_tag = '0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, out_data, out_tag, out_zero} !== {1'b0, 32'd0, 5'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_async: got v=%b d=%h t=%h z=%b want v=0 d=0 t=0 z=1",
                     out_valid, out_data, out_tag, out_zero);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({a_valid, a_data, a_zero, b_valid, b_data, b_zero} !== {1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_w8: got a=%b/%h/%b b=%b/%h/%b want 0/00/1 each",
                     a_valid, a_data, a_zero, b_valid, b_data, b_zero);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] dv [5];
        int          av [5];
        logic [1:0]  ov [5];
        logic [31:0] ev [5];
        dv = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 32'h1234_5678};
        av = '{31, 4, 31, 1, 0};
        ov = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
        ev = '{32'h0000_0001, 32'hF800_0000, 32'h8000_0000,
               ROT ? 32'h8000_0000 : 32'h0000_0000, 32'h1234_5678};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_op(dv[i], av[i], ov[i], 5'(i + 1));
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL directed%0d_early: out_valid=%b want 0 one cycle after accept", i, out_valid);
            end
            @(posedge clk); #1;
            @(negedge clk);
            vectors++;
            if ({out_valid, out_data, out_tag, out_zero} !== {1'b1, ev[i], 5'(i + 1), ev[i] == 32'd0}) begin
                miscompares++;
                $display("FAIL directed%0d: got v=%b d=%h t=%0d z=%b want v=1 d=%h t=%0d z=%b",
                         i, out_valid, out_data, out_tag, out_zero, ev[i], i + 1, ev[i] == 32'd0);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) drive_random(5'(i + 1));
            else in_valid = 1'b0;
            @(negedge clk);
            vectors++;
            if (out_valid !== (i >= 2 && i < 6)) begin
                miscompares++;
                $display("FAIL b2b_valid cycle %0d: got %b want %b", i, out_valid, (i >= 2 && i < 6));
            end
            if (i < 4) begin
                vectors++;
                if (in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_in_ready cycle %0d: got %b want 1", i, in_ready);
                end
            end
            if (out_valid && q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if ({out_data, out_tag} !== {e.data, e.tag}) begin
                    miscompares++;
                    $display("FAIL b2b_result: got %h/%0d want %h/%0d", out_data, out_tag, e.data, e.tag);
                end
            end
            if (in_valid && in_ready) begin
                e.data = ref_shift(in_data, int'(in_amt), in_op, 32);
                e.tag  = in_tag;
                q.push_back(e);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_drain: %0d results missing, want 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   got;
        got = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i < 6) drive_random(5'(20 + i));
            else in_valid = 1'b0;
            if (i == 6) out_ready = 1'b1;
            @(negedge clk);
            if (i >= 2 && i < 6) begin
                vectors++;
                if (q.size() == 0 || {out_valid, in_ready, out_data, out_tag} !== {1'b1, 1'b0, q[0].data, q[0].tag}) begin
                    miscompares++;
                    $display("FAIL bp_hold cycle %0d: got v=%b rdy=%b d=%h t=%0d want v=1 rdy=0 held head",
                             i, out_valid, in_ready, out_data, out_tag);
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL bp_extra: got %h/%0d want no result", out_data, out_tag);
                end else begin
                    e = q.pop_front();
                    got++;
                    if ({out_data, out_tag} !== {e.data, e.tag}) begin
                        miscompares++;
                        $display("FAIL bp_result: got %h/%0d want %h/%0d", out_data, out_tag, e.data, e.tag);
                    end
                end
            end
            if (in_valid && in_ready) begin
                e.data = ref_shift(in_data, int'(in_amt), in_op, 32);
                e.tag  = in_tag;
                q.push_back(e);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (got != 2 || q.size() != 0) begin
            miscompares++;
            $display("FAIL bp_count: delivered %0d pending %0d want 2 and 0", got, q.size());
            q.delete();
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 0) drive_random(5'd9);
            else if (i == 1) begin
                drive_op(32'h0000_00FF, 3, 2'b00, 5'd10);
                flush = 1'b1;
            end else begin
                in_valid = 1'b0;
                flush    = 1'b0;
            end
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush cycle %0d: out_valid=%b data=%h want 0", i, out_valid, out_data);
            end
            @(posedge clk); #1;
        end
        flush = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_random(5'(12 + i));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_pre: out_valid=%b want 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, out_data, out_tag, out_zero} !== {1'b0, 32'd0, 5'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL arst_immediate: got v=%b d=%h t=%0d z=%b want 0/0/0/1",
                     out_valid, out_data, out_tag, out_zero);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        @(posedge clk); #1;
        drive_op(32'h0000_000A, 0, 2'b10, 5'd7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_stale: out_valid=%b data=%h want 0", out_valid, out_data);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if ({out_valid, out_data, out_tag, out_zero} !== {1'b1, 32'h0000_000A, 5'd7, 1'b0}) begin
            miscompares++;
            $display("FAIL arst_first_op: got v=%b d=%h t=%0d z=%b want 1/0000000a/7/0",
                     out_valid, out_data, out_tag, out_zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        exp_t e;
        for (int i = 0; i < 320; i++) begin
            if (i < 300 && $urandom_range(0, 9) < 7) drive_random(5'($urandom));
            else in_valid = 1'b0;
            out_ready = (i >= 300) || ($urandom_range(0, 9) < 7);
            @(negedge clk);
            vectors++;
            if (in_ready !== (!out_valid || out_ready)) begin
                miscompares++;
                $display("FAIL rand_in_ready cycle %0d: got %b want %b", i, in_ready, (!out_valid || out_ready));
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_extra cycle %0d: got %h want no result", i, out_data);
                end else begin
                    e = q.pop_front();
                    if ({out_data, out_tag, out_zero} !== {e.data, e.tag, e.data == 32'd0}) begin
                        miscompares++;
                        $display("FAIL rand_result cycle %0d: got %h/%0d/%b want %h/%0d/%b",
                                 i, out_data, out_tag, out_zero, e.data, e.tag, e.data == 32'd0);
                    end
                end
            end
            if (in_valid && in_ready) begin
                e.data = ref_shift(in_data, int'(in_amt), in_op, 32);
                e.tag  = in_tag;
                q.push_back(e);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL rand_drain: %0d results never delivered, want 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_sweep8();
        exp_t e;
        for (int i = 0; i < 38; i++) begin
            if (i < 32) begin
                s_valid = 1'b1;
                s_op    = 2'(i / 8);
                s_amt   = 3'(i % 8);
                s_data  = 8'($urandom);
                s_tag   = 5'(i);
            end else s_valid = 1'b0;
            @(negedge clk);
            vectors++;
            if ({a_valid, b_valid} !== {(i >= 1 && i < 33), (i >= 3 && i < 35)}) begin
                miscompares++;
                $display("FAIL w8_valid cycle %0d: got s1=%b s3=%b want %b %b",
                         i, a_valid, b_valid, (i >= 1 && i < 33), (i >= 3 && i < 35));
            end
            if (a_valid && qa.size() > 0) begin
                e = qa.pop_front();
                vectors++;
                if ({a_data, a_tag, a_zero} !== {e.data[7:0], e.tag, e.data == 32'd0}) begin
                    miscompares++;
                    $display("FAIL w8_s1 tag %0d: got %h/%0d/%b want %h/%0d/%b",
                             e.tag, a_data, a_tag, a_zero, e.data[7:0], e.tag, e.data == 32'd0);
                end
            end
            if (b_valid && qb.size() > 0) begin
                e = qb.pop_front();
                vectors++;
                if ({b_data, b_tag, b_zero} !== {e.data[7:0], e.tag, e.data == 32'd0}) begin
                    miscompares++;
                    $display("FAIL w8_s3 tag %0d: got %h/%0d/%b want %h/%0d/%b",
                             e.tag, b_data, b_tag, b_zero, e.data[7:0], e.tag, e.data == 32'd0);
                end
            end
            if (s_valid && a_ready && b_ready) begin
                e.data = ref_shift({24'd0, s_data}, int'(s_amt), s_op, 8);
                e.tag  = s_tag;
                qa.push_back(e);
                qb.push_back(e);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (qa.size() != 0 || qb.size() != 0) begin
            miscompares++;
            $display("FAIL w8_drain: pending s1=%0d s3=%0d want 0", qa.size(), qb.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        test_sweep8();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
